// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the data-side RAM responder: FSM encoding, bus constants, lane helpers.
package data_ram_responder_pkg;

  typedef enum logic [1:0] {
    DRAM_IDLE = 2'b00,
    DRAM_WAIT = 2'b01,
    DRAM_RESP = 2'b10
  } dram_state_e;

  localparam int                RegBus      = 32;
  localparam logic              ChipEnable  = 1'b1;
  localparam logic              WriteEnable = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord    = '0;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  // Lane k carries data[8k+7:8k]; lane 3 is byte offset 0 (big-endian).
  function automatic logic [LANES-1:0] lane_mask(input int k);
    return 4'(1 << k);
  endfunction

endpackage

// File: rtl/data_ram_responder_if.sv
// MEM-stage request/response bus between the requester (master) and the data RAM (slave).
interface data_ram_responder_if;
  import data_ram_responder_pkg::*;

  logic              mem_ce_i;
  logic              mem_we_i;
  logic [RegBus-1:0] mem_addr_i;
  logic [LANES-1:0]  mem_sel_i;
  logic [RegBus-1:0] mem_data_i;
  logic [RegBus-1:0] mem_data_o;
  logic              stallreq_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, stallreq_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, stallreq_o
  );

endinterface

// File: rtl/data_ram_array.sv
// Word-organised RAM built from four byte banks: synchronous per-lane write, asynchronous word read.
module data_ram_array
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [LANES-1:0]  sel_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [RegBus-1:0] wdata_i,
  output logic [RegBus-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  for (genvar k = 0; k < LANES; k++) begin : g_bank
    logic [LANE_W-1:0] bank_q [DEPTH];
    logic              lane_we;

    assign lane_we = we_i && ((sel_i & lane_mask(k)) != '0);

    always_ff @(posedge clk) begin
      if (lane_we) begin
        bank_q[addr_i] <= wdata_i[k*LANE_W +: LANE_W];
      end
    end

    assign rdata_o[k*LANE_W +: LANE_W] = bank_q[addr_i];
  end

endmodule

// File: rtl/data_ram_responder.sv
// Data-side memory responder: one-cycle byte-lane writes, reads with WAIT_CYC extra stall cycles.
// Optional read/write statistics counters are built when DATA_RAM_STATS_EN is defined.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input logic                 clk,
  input logic                 rst,
  data_ram_responder_if.slave mem_if
`ifdef DATA_RAM_STATS_EN
  ,
  output logic [RegBus-1:0]   rd_cnt_o,
  output logic [RegBus-1:0]   wr_cnt_o
`endif
);

  localparam int         WAIT_LOAD_I = (WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0;
  localparam logic [3:0] WAIT_LOAD   = WAIT_LOAD_I[3:0];

  dram_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [RegBus-1:0] rdata_q, rdata_d;
  logic              stall;
  logic              wr_en;
  logic [RegBus-1:0] arr_rdata;
  logic [ADDR_W-1:0] word_idx;
  logic              unused_addr_bits;

  // Upper address bits alias onto the same word; byte offset is carried by sel.
  assign word_idx         = mem_if.mem_addr_i[ADDR_W+1:2];
  assign unused_addr_bits = ^{mem_if.mem_addr_i[RegBus-1:ADDR_W+2], mem_if.mem_addr_i[1:0]};

  data_ram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we_i    (wr_en),
    .sel_i   (mem_if.mem_sel_i),
    .addr_i  (word_idx),
    .wdata_i (mem_if.mem_data_i),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DRAM_IDLE;
      cnt_q   <= '0;
      rdata_q <= ZeroWord;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    stall   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      DRAM_IDLE: begin
        if (mem_if.mem_ce_i == ChipEnable) begin
          if (mem_if.mem_we_i == WriteEnable) begin
            wr_en = 1'b1;
          end else begin
            stall = 1'b1;
            if (WAIT_CYC == 0) begin
              rdata_d = arr_rdata;
              state_d = DRAM_RESP;
            end else begin
              cnt_d   = WAIT_LOAD;
              state_d = DRAM_WAIT;
            end
          end
        end
      end
      DRAM_WAIT: begin
        stall = 1'b1;
        // A dropped request abandons the read without touching the output word.
        if (mem_if.mem_ce_i != ChipEnable) begin
          state_d = DRAM_IDLE;
        end else if (cnt_q == 4'd0) begin
          rdata_d = arr_rdata;
          state_d = DRAM_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DRAM_RESP: begin
        state_d = DRAM_IDLE;
      end
      default: begin
        state_d = DRAM_IDLE;
      end
    endcase
  end

  assign mem_if.stallreq_o = stall;
  assign mem_if.mem_data_o = rdata_q;

`ifdef DATA_RAM_STATS_EN
  logic [RegBus-1:0] rd_cnt_q, rd_cnt_d;
  logic [RegBus-1:0] wr_cnt_q, wr_cnt_d;

  function automatic logic [RegBus-1:0] sat_inc(input logic [RegBus-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // RESP is only ever entered from IDLE or WAIT, so this counts each completed read once.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_d == DRAM_RESP) rd_cnt_d = sat_inc(rd_cnt_q);
    if (wr_en)                wr_cnt_d = sat_inc(wr_cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
